// File: rtl/jtopl_wrseq.sv
// OPL2 host write sequencer: FIFOs {reg,val} pairs and replays them on the OPL CPU port
// with address/data recovery waits; also serves single status-register reads.
`timescale 1ns/1ps
module jtopl_wrseq #(
   parameter int FIFO_AW   = 2,
   parameter int ADDR_WAIT = 12,
   parameter int DATA_WAIT = 84
) (
   input  logic       rst,
   input  logic       clk,
   input  logic       cen,
   input  logic       req_valid,
   input  logic [7:0] req_reg,
   input  logic [7:0] req_val,
   output logic       req_ready,
   input  logic       stat_rd,
   output logic [7:0] stat,
   output logic       stat_valid,
   output logic       busy,
   output logic [7:0] opl_din,
   output logic       opl_addr,
   output logic       opl_cs_n,
   output logic       opl_wr_n,
   input  logic [7:0] opl_dout
);
   localparam int DEPTH = 1 << FIFO_AW;

   typedef enum logic [2:0] {IDLE, WADDR, AWAIT, WDATA, DWAIT, SREAD} state_t;

   logic [15:0]        mem [DEPTH];
   logic [15:0]        rd_data_reg;
   logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [FIFO_AW:0]   count_reg, count_next;
   logic               req_ready_reg, avail_reg;
   logic               push, pop, head_ok;

   state_t     state_reg;
   logic [7:0] cnt_reg, hold_val_reg;
   logic       pend_reg;
   logic [7:0] stat_reg, din_reg;
   logic       stat_valid_reg, addr_reg, cs_n_reg, wr_n_reg;

   // avail_reg lags the count by one clk so the registered RAM read is settled
   // before the FSM consumes the head entry.
   assign head_ok = avail_reg && (count_reg != '0);
   assign push    = req_valid && req_ready_reg;
   assign pop     = cen && (state_reg == IDLE) && !pend_reg && head_ok;

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= {req_reg, req_val};
      rd_data_reg <= mem[rd_ptr_reg];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         req_ready_reg <= 1'b0;
         avail_reg     <= 1'b0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg     <= count_next;
         req_ready_reg <= !count_next[FIFO_AW];   // count never exceeds DEPTH
         avail_reg     <= (count_reg != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         hold_val_reg   <= '0;
         pend_reg       <= 1'b0;
         stat_reg       <= '0;
         stat_valid_reg <= 1'b0;
         din_reg        <= '0;
         addr_reg       <= 1'b0;
         cs_n_reg       <= 1'b1;
         wr_n_reg       <= 1'b1;
      end else begin
         stat_valid_reg <= 1'b0;
         if (cen) begin
            case (state_reg)
               IDLE: begin
                  if (pend_reg) begin
                     pend_reg  <= 1'b0;
                     cs_n_reg  <= 1'b0;
                     wr_n_reg  <= 1'b1;
                     addr_reg  <= 1'b0;
                     state_reg <= SREAD;
                  end else if (head_ok) begin
                     hold_val_reg <= rd_data_reg[7:0];
                     din_reg      <= rd_data_reg[15:8];
                     cs_n_reg     <= 1'b0;
                     wr_n_reg     <= 1'b0;
                     addr_reg     <= 1'b0;
                     state_reg    <= WADDR;
                  end
               end
               WADDR: begin
                  cs_n_reg  <= 1'b1;
                  wr_n_reg  <= 1'b1;
                  cnt_reg   <= 8'(ADDR_WAIT - 1);
                  state_reg <= AWAIT;
               end
               AWAIT: begin
                  if (cnt_reg == '0) begin
                     din_reg   <= hold_val_reg;
                     cs_n_reg  <= 1'b0;
                     wr_n_reg  <= 1'b0;
                     addr_reg  <= 1'b1;
                     state_reg <= WDATA;
                  end else begin
                     cnt_reg <= cnt_reg - 1'b1;
                  end
               end
               WDATA: begin
                  cs_n_reg  <= 1'b1;
                  wr_n_reg  <= 1'b1;
                  cnt_reg   <= 8'(DATA_WAIT - 1);
                  state_reg <= DWAIT;
               end
               DWAIT: begin
                  if (cnt_reg == '0) state_reg <= IDLE;
                  else               cnt_reg   <= cnt_reg - 1'b1;
               end
               SREAD: begin
                  stat_reg       <= opl_dout;
                  stat_valid_reg <= 1'b1;
                  cs_n_reg       <= 1'b1;
                  wr_n_reg       <= 1'b1;
                  state_reg      <= IDLE;
               end
               default: state_reg <= IDLE;
            endcase
         end
         // A request arriving during a read re-arms the flag for a second read.
         if (stat_rd) pend_reg <= 1'b1;
      end
   end

   assign req_ready  = req_ready_reg;
   assign stat       = stat_reg;
   assign stat_valid = stat_valid_reg;
   assign busy       = (count_reg != '0) || pend_reg || (state_reg != IDLE);
   assign opl_din    = din_reg;
   assign opl_addr   = addr_reg;
   assign opl_cs_n   = cs_n_reg;
   assign opl_wr_n   = wr_n_reg;
endmodule

// File: tb/tb_jtopl_wrseq.sv
// Directed bench for jtopl_wrseq: bus strobes are logged by a monitor and compared
// against hand-computed timing and data.
`timescale 1ns/1ps
module tb_jtopl_wrseq;
   logic       clk = 1'b0;
   logic       rst, cen, req_valid, stat_rd;
   logic [7:0] req_reg, req_val, opl_dout;
   logic       req_ready, stat_valid, busy, opl_addr, opl_cs_n, opl_wr_n;
   logic [7:0] stat, opl_din;

   jtopl_wrseq dut (
      .rst(rst), .clk(clk), .cen(cen),
      .req_valid(req_valid), .req_reg(req_reg), .req_val(req_val), .req_ready(req_ready),
      .stat_rd(stat_rd), .stat(stat), .stat_valid(stat_valid), .busy(busy),
      .opl_din(opl_din), .opl_addr(opl_addr), .opl_cs_n(opl_cs_n), .opl_wr_n(opl_wr_n),
      .opl_dout(opl_dout)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         start;
      int         len;
      logic       addr;
      logic       wr_n;
      logic [7:0] din;
   } strobe_t;

   strobe_t strobes[$];
   int      cyc = 0;
   int      cdiv = 0;
   bit      quarter = 1'b0;
   bit      cen_off = 1'b0;
   int      sv_count = 0;
   logic [7:0] sv_stat = 8'h00;
   int      errors = 0;
   int      checks = 0;
   int      idle_cyc = 0;
   int      push_cyc = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      cen = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         cdiv++;
         cen = cen_off ? 1'b0 : (quarter ? (cdiv % 4 == 0) : 1'b1);
      end
   end

   // Strobe monitor: one record per cs_n low window, timed in clk edges.
   initial begin
      logic    prev_cs;
      strobe_t cur;
      prev_cs = 1'b1;
      cur = '{start: 0, len: 0, addr: 1'b0, wr_n: 1'b1, din: 8'h00};
      forever begin
         @(negedge clk);
         if (!opl_cs_n) begin
            if (prev_cs) begin
               cur.start = cyc;
               cur.len   = 1;
               cur.addr  = opl_addr;
               cur.wr_n  = opl_wr_n;
               cur.din   = opl_din;
            end else begin
               cur.len++;
            end
         end else if (!prev_cs) begin
            strobes.push_back(cur);
         end
         if (stat_valid) begin
            sv_count++;
            sv_stat = stat;
         end
         prev_cs = opl_cs_n;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] r, input logic [7:0] v);
      req_valid = 1'b1;
      req_reg   = r;
      req_val   = v;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int n;
      n = 0;
      while (busy && n < max) begin
         tick();
         n++;
      end
      idle_cyc = cyc;
      check("idle_timeout", busy, 1'b0);
   endtask

   task automatic wait_strobes(input int want, input int max);
      int n;
      n = 0;
      while (strobes.size() < want && n < max) begin
         tick();
         n++;
      end
      check("strobe_timeout", strobes.size() >= want, 1'b1);
   endtask

   // Single write: address strobe, 12*k idle, data strobe, 84*k idle until busy falls.
   task automatic single_write(input string tag, input int k, input bit chk_lat);
      strobes.delete();
      push(8'h20, 8'h01);
      push_cyc = cyc;
      wait_idle(400 * k);
      check({tag, "_n"}, strobes.size(), 2);
      if (strobes.size() >= 2) begin
         if (chk_lat) check({tag, "_lat"}, strobes[0].start - push_cyc, 2);
         check({tag, "_a_len"},  strobes[0].len, k);
         check({tag, "_a_addr"}, strobes[0].addr, 1'b0);
         check({tag, "_a_wrn"},  strobes[0].wr_n, 1'b0);
         check({tag, "_a_din"},  strobes[0].din, 8'h20);
         check({tag, "_a_gap"},  strobes[1].start - (strobes[0].start + strobes[0].len), 12 * k);
         check({tag, "_d_len"},  strobes[1].len, k);
         check({tag, "_d_addr"}, strobes[1].addr, 1'b1);
         check({tag, "_d_din"},  strobes[1].din, 8'h01);
         check({tag, "_d_gap"},  idle_cyc - (strobes[1].start + strobes[1].len), 84 * k);
      end
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; stat_rd = 1'b0;
      req_reg = 8'h00; req_val = 8'h00; opl_dout = 8'h00;
      repeat (3) tick();
      check("rst_cs_n", opl_cs_n, 1'b1);
      check("rst_wr_n", opl_wr_n, 1'b1);
      check("rst_addr", opl_addr, 1'b0);
      check("rst_din", opl_din, 8'h00);
      check("rst_stat", stat, 8'h00);
      check("rst_stat_valid", stat_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_ready", req_ready, 1'b0);
      rst = 1'b0;
      tick();
      check("rel_ready", req_ready, 1'b1);
      check("rel_busy", busy, 1'b0);

      single_write("w1", 1, 1'b1);

      quarter = 1'b1;
      tick();
      single_write("q4", 4, 1'b0);
      quarter = 1'b0;
      tick();

      // FIFO full: pushes while cen is held low, fifth one must be dropped.
      cen_off = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         push(8'h40 + 8'(i), 8'h10 + 8'(i));
         if (i == 3) check("full_ready_4", req_ready, 1'b0);
      end
      check("full_ready_5", req_ready, 1'b0);
      check("full_busy", busy, 1'b1);
      strobes.delete();
      cen_off = 1'b0;
      wait_idle(1500);
      check("full_n", strobes.size(), 8);
      if (strobes.size() >= 8) begin
         for (int i = 0; i < 4; i++) begin
            check($sformatf("full_reg%0d", i), strobes[2*i].din, 8'h40 + 8'(i));
            check($sformatf("full_val%0d", i), strobes[2*i+1].din, 8'h10 + 8'(i));
         end
         check("full_spacing", strobes[2].start - strobes[0].start, 99);
      end
      check("full_ready_after", req_ready, 1'b1);

      // Status read requested during the first pair's data wait.
      strobes.delete();
      sv_count = 0;
      opl_dout = 8'hE0;
      push(8'h60, 8'h70);
      push(8'h61, 8'h71);
      wait_strobes(2, 200);
      repeat (5) tick();
      stat_rd = 1'b1;
      tick();
      stat_rd = 1'b0;
      wait_idle(1000);
      check("rd_n", strobes.size(), 5);
      if (strobes.size() >= 5) begin
         check("rd_wrn", strobes[2].wr_n, 1'b1);
         check("rd_addr", strobes[2].addr, 1'b0);
         check("rd_len", strobes[2].len, 1);
         check("rd_next_reg", strobes[3].din, 8'h61);
         check("rd_next_val", strobes[4].din, 8'h71);
      end
      check("rd_pulses", sv_count, 1);
      check("rd_pulse_stat", sv_stat, 8'hE0);
      check("rd_stat", stat, 8'hE0);

      // Reset during the address wait with two entries still queued.
      strobes.delete();
      push(8'h80, 8'h90);
      push(8'h81, 8'h91);
      push(8'h82, 8'h92);
      wait_strobes(1, 100);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      check("mid_cs_n", opl_cs_n, 1'b1);
      check("mid_busy", busy, 1'b0);
      rst = 1'b0;
      tick();
      check("mid_ready", req_ready, 1'b1);
      strobes.delete();
      repeat (200) tick();
      check("mid_no_strobe", strobes.size(), 0);
      check("mid_busy_after", busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
